text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
Upstream feeder for the text drawer's character display buffer. It accepts a byte stream of characters, e.g. from the CPU output port or UART, with a valid/ready handshake. It tracks a cursor on the 80x30 character grid and emits single-cycle buffer writes (buffer_write_enable, position, char_code). It also handles control codes and clears the screen after reset. The display buffer is write-only from this side, so there is no scrolling: on wrap the cursor returns to row 0, and every row is blanked on entry.

Parameters:
COLS, 80, characters per row (640 px / 8)
ROWS, 30, character rows (480 px / 16)
ADDR_W, 12, width of position; COLS*ROWS must be <= 2**ADDR_W
BLANK, 7'h20, code written when clearing

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
char_valid  in  1  char_in holds a byte to consume
char_in  in  8  input byte
ready  out  1  block can accept a byte this cycle
buffer_write_enable  out  1  one-cycle write strobe to display buffer
position  out  ADDR_W  write address = cursor_row*COLS + cursor_col
char_code  out  7  code to write
cursor_row  out  5  current cursor row, 0..ROWS-1
cursor_col  out  7  current cursor column, 0..COLS-1

Behaviour:
- Handshake: a byte is accepted on a rising edge where char_valid && ready. ready is high only in IDLE and is a combinational function of state.
- All outputs are registered except ready.
- Reset (reset==0 at an edge), which takes effect even mid-operation:
  - state=CLEAR, cursor=(0,0), row_base=0
  - buffer_write_enable=0, position=0, char_code=BLANK
- States: CLEAR, IDLE, ROWCLR.
- CLEAR:
  - writes BLANK to positions 0..COLS*ROWS-1, one per cycle: 2400 consecutive strobes.
  - Goes to IDLE on the cycle after the last write.
  - Cursor stays at (0,0).
- Accepted byte, decoded in IDLE; the write (if any) appears the cycle after acceptance:
  - 0x20..0x7E: write char_in[6:0] at the cursor, then advance col. If col was COLS-1, do a newline (below).
  - 0x0A (LF): newline. col=0, row=row+1; row ROWS-1 wraps to 0. Then enter ROWCLR for the new row.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS): if col>0, col=col-1 and write BLANK at the new position. At col 0: no effect, no write.
  - 0x0C (FF): cursor=(0,0), enter CLEAR.
  - Any other byte: consumed and ignored, no write.
- ROWCLR:
  - writes BLANK to row_base+0 .. row_base+COLS-1 on COLS consecutive cycles, then returns to IDLE.
  - For a printable char at col COLS-1, the char write precedes the ROWCLR writes; ROWCLR starts the cycle after.
- Address arithmetic:
  - No multiplier. row_base is kept as a register, +COLS per row step, reset to 0 on wrap.
  - position = row_base + col, computed at ADDR_W width.
  - The clear counter is ADDR_W wide.
- char_valid while ready=0 is ignored; the byte must be held by the source.
- At most one strobe per cycle. The cursor always points at the next write slot.

Decomposition:
- Shared package text_console_pkg holds:
  - COLS, ROWS, BLANK
  - control code constants CH_LF, CH_CR, CH_BS, CH_FF
  - state enum {CLEAR, IDLE, ROWCLR}
- The same package is used by the drawer's address computation.
- One natural sub-module: cursor_tracker, which holds row/col/row_base with inc/newline/back/home controls. The FSM and write-port register stay in the top.

Test Plan:
- Release reset, hold char_valid=0 -> exactly 2400 strobes, positions 0..2399 in order, char_code=0x20. ready rises the cycle after position 2399. Cursor is (0,0).
- After clear, send "Hi" (0x48, 0x69) -> writes (0,0x48) then (1,0x69). Cursor is (0,2). ready is high every cycle.
- Cursor at (0,79), send 0x41 -> write (79,0x41), then 80 BLANK writes at 80..159, ready low for 80 cycles. Cursor ends at (1,0).
- Cursor at (29,5), send 0x0A -> cursor (0,0), BLANK writes 0..79. Then send 0x0D at (3,10) -> cursor (3,0), no strobe.
- Cursor (2,0), send 0x08 -> no strobe. Cursor (2,4), send 0x08 -> write (163,0x20), cursor (2,3). Send 0x07 -> consumed, no strobe, cursor unchanged.
- Assert reset at strobe 40 of a ROWCLR and at strobe 1000 of an FF clear -> next cycle strobe=0. Then a fresh full 2400-write clear from position 0.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and write payload for the text console
// writer and the drawer's address computation.
package text_console_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned CODE_W = 7;
  localparam int unsigned SCREEN = COLS * ROWS;

  localparam logic [CODE_W-1:0] BLANK = 7'h20;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_CNT_END = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCR_CNT_END = ADDR_W'(SCREEN - 1);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ROWCLR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] position;
    logic [CODE_W-1:0] code;
  } buf_write_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer_cursor_tracker.sv
// Cursor position on the character grid plus the matching row base address,
// so the write address never needs a multiplier.
module cursor_tracker
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              newline,
  input  logic              back,
  input  logic              home,
  input  logic              cr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] row_base
);

  logic [ROW_W-1:0]  row_d;
  logic [COL_W-1:0]  col_d;
  logic [ADDR_W-1:0] row_base_d;

  // An advance past the last column behaves exactly like a newline.
  always_comb begin
    row_d      = row;
    col_d      = col;
    row_base_d = row_base;
    if (home) begin
      row_d      = '0;
      col_d      = '0;
      row_base_d = '0;
    end else if (newline || (inc && (col == COL_LAST))) begin
      col_d = '0;
      if (row == ROW_LAST) begin
        row_d      = '0;
        row_base_d = '0;
      end else begin
        row_d      = row + ROW_W'(1);
        row_base_d = row_base + ADDR_W'(COLS);
      end
    end else if (inc) begin
      col_d = col + COL_W'(1);
    end else if (back && (col != '0)) begin
      col_d = col - COL_W'(1);
    end else if (cr) begin
      col_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row      <= '0;
      col      <= '0;
      row_base <= '0;
    end else begin
      row      <= row_d;
      col      <= col_d;
      row_base <= row_base_d;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to character-buffer writer: decodes printable and control
// codes, tracks the cursor and blanks the screen / new rows.
module text_console_writer
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_in,
  output logic              ready,
  output logic              buffer_write_enable,
  output logic [ADDR_W-1:0] position,
  output logic [CODE_W-1:0] char_code,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic              wr_en_d;
  buf_write_t        wr_d;
  logic              accept;
  logic              cur_inc, cur_newline, cur_back, cur_home, cur_cr;
  logic [ADDR_W-1:0] row_base;

  assign ready  = (state == IDLE);
  assign accept = char_valid && ready;

  cursor_tracker u_cursor (
    .clk      (clk),
    .reset    (reset),
    .inc      (cur_inc),
    .newline  (cur_newline),
    .back     (cur_back),
    .home     (cur_home),
    .cr       (cur_cr),
    .row      (cursor_row),
    .col      (cursor_col),
    .row_base (row_base)
  );

  always_comb begin
    state_d      = state;
    clr_cnt_d    = clr_cnt;
    wr_en_d      = 1'b0;
    wr_d         = '{position: position, code: char_code};
    cur_inc      = 1'b0;
    cur_newline  = 1'b0;
    cur_back     = 1'b0;
    cur_home     = 1'b0;
    cur_cr       = 1'b0;
    unique case (state)
      CLEAR: begin
        wr_en_d = 1'b1;
        wr_d    = '{position: clr_cnt, code: BLANK};
        if (clr_cnt == SCR_CNT_END) state_d = IDLE;
        else clr_cnt_d = clr_cnt + ADDR_W'(1);
      end
      ROWCLR: begin
        wr_en_d = 1'b1;
        wr_d    = '{position: row_base + clr_cnt, code: BLANK};
        if (clr_cnt == ROW_CNT_END) state_d = IDLE;
        else clr_cnt_d = clr_cnt + ADDR_W'(1);
      end
      IDLE: begin
        if (accept) begin
          if (is_printable(char_in)) begin
            wr_en_d = 1'b1;
            wr_d    = '{position: row_base + ADDR_W'(cursor_col), code: char_in[6:0]};
            cur_inc = 1'b1;
            // Writing the last column wraps, and the new row must be blanked.
            if (cursor_col == COL_LAST) begin
              state_d   = ROWCLR;
              clr_cnt_d = '0;
            end
          end else begin
            case (char_in)
              CH_LF: begin
                cur_newline = 1'b1;
                state_d     = ROWCLR;
                clr_cnt_d   = '0;
              end
              CH_CR: cur_cr = 1'b1;
              CH_BS: begin
                if (cursor_col != '0) begin
                  cur_back = 1'b1;
                  wr_en_d  = 1'b1;
                  wr_d     = '{position: row_base + ADDR_W'(cursor_col) - ADDR_W'(1),
                               code: BLANK};
                end
              end
              CH_FF: begin
                cur_home  = 1'b1;
                state_d   = CLEAR;
                clr_cnt_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= CLEAR;
      clr_cnt             <= '0;
      buffer_write_enable <= 1'b0;
      position            <= '0;
      char_code           <= BLANK;
    end else begin
      state               <= state_d;
      clr_cnt             <= clr_cnt_d;
      buffer_write_enable <= wr_en_d;
      position            <= wr_d.position;
      char_code           <= wr_d.code;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a grid-level model queues the
// expected buffer writes, a negedge monitor pops and compares each strobe.
module tb_text_console_writer;
  import text_console_pkg::*;

  localparam int NCOL = 80;
  localparam int NROW = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic              char_valid;
  logic [7:0]        char_in;
  logic              ready;
  logic              buffer_write_enable;
  logic [ADDR_W-1:0] position;
  logic [CODE_W-1:0] char_code;
  logic [ROW_W-1:0]  cursor_row;
  logic [COL_W-1:0]  cursor_col;

  text_console_writer dut (
    .clk                 (clk),
    .reset               (reset),
    .char_valid          (char_valid),
    .char_in             (char_in),
    .ready               (ready),
    .buffer_write_enable (buffer_write_enable),
    .position            (position),
    .char_code           (char_code),
    .cursor_row          (cursor_row),
    .cursor_col          (cursor_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int code;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  fails  = 0;
  int  m_row  = 0;
  int  m_col  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (buffer_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: got pos=%0d code=%0h, expected no write (t=%0t)",
                 position, char_code, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("position", int'(position), mon_e.pos);
        check("char_code", int'(char_code), mon_e.code);
      end
    end
  end

  // Reference model at grid level: positions are row*COLS+col.
  task automatic m_push(input int pos, input int code);
    wr_t e;
    e.pos  = pos;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic m_newline();
    m_col = 0;
    m_row = (m_row + 1) % NROW;
    for (int i = 0; i < NCOL; i++) m_push(m_row * NCOL + i, 'h20);
  endtask

  task automatic m_clear_screen();
    for (int i = 0; i < NCOL * NROW; i++) m_push(i, 'h20);
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_push(m_row * NCOL + m_col, int'(b) & 'h7F);
      m_col++;
      if (m_col == NCOL) m_newline();
    end else if (b == 8'h0A) begin
      m_newline();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_push(m_row * NCOL + m_col, 'h20);
      end
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      m_clear_screen();
    end
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, int'(cursor_row), m_row);
    check({tag, "_col"}, int'(cursor_col), m_col);
  endtask

  // Byte is presented before ready so a busy DUT must ignore it.
  task automatic send(input logic [7:0] b);
    int n;
    n          = 0;
    char_valid = 1'b1;
    char_in    = b;
    while (ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 5000) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    m_byte(b);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'($urandom);
    check_cursor("cursor");
  endtask

  task automatic wait_idle(output int low);
    int n;
    low = 0;
    n   = 0;
    while (!(ready === 1'b1 && exp_q.size() == 0)) begin
      if (ready !== 1'b1) low++;
      @(posedge clk);
      #1;
      n++;
      if (n > 10000) begin
        check("idle_timeout", exp_q.size(), 0);
        break;
      end
    end
  endtask

  task automatic do_reset();
    int low;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_strobe", int'(buffer_write_enable), 0);
    check("reset_ready", int'(ready), 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    check_cursor("reset_cursor");
    m_clear_screen();
    reset = 1'b1;
    wait_idle(low);
    check("clear_ready_low_cycles", low, NCOL * NROW);
    check_cursor("after_clear");
  endtask

  initial begin
    int low;
    int r;
    logic [7:0] b;
    reset      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();

    // "Hi" with no busy cycles
    send(8'h48);
    wait_idle(low);
    check("hi_ready_low_H", low, 0);
    send(8'h69);
    wait_idle(low);
    check("hi_ready_low_i", low, 0);
    check_cursor("after_hi");

    // Fill to column 79, then wrap on the last column
    for (int i = 0; i < 77; i++) send(8'h61 + 8'(i % 26));
    wait_idle(low);
    check("col_before_wrap", int'(cursor_col), 79);
    send(8'h41);
    wait_idle(low);
    check("wrap_ready_low_cycles", low, NCOL);
    check_cursor("after_wrap");

    // Bottom row LF wraps to row 0
    for (int i = 0; i < 28; i++) begin
      send(8'h0A);
      wait_idle(low);
    end
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    check("row_before_lf_wrap", int'(cursor_row), 29);
    send(8'h0A);
    wait_idle(low);
    check("lf_ready_low_cycles", low, NCOL);
    check_cursor("after_lf_wrap");

    // CR at (3,10)
    for (int i = 0; i < 3; i++) begin
      send(8'h0A);
      wait_idle(low);
    end
    for (int i = 0; i < 10; i++) send(8'h7E - 8'(i));
    send(8'h0D);
    wait_idle(low);
    check_cursor("after_cr");

    // FF, then backspace at col 0 and col 4, then an ignored code
    send(8'h0C);
    wait_idle(low);
    check("ff_ready_low_cycles", low, NCOL * NROW);
    send(8'h0A);
    send(8'h0A);
    wait_idle(low);
    send(8'h08);
    wait_idle(low);
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    send(8'h08);
    send(8'h07);
    wait_idle(low);
    check_cursor("after_bs");

    // Reset in the middle of a row clear and of a full clear
    send(8'h0A);
    repeat (40) @(posedge clk);
    #1;
    do_reset();
    send(8'h0C);
    repeat (1000) @(posedge clk);
    #1;
    do_reset();

    // Randomized byte stream
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) b = 8'($urandom_range(32, 126));
      else if (r < 80) b = 8'h0A;
      else if (r < 86) b = 8'h0D;
      else if (r < 93) b = 8'h08;
      else if (r < 98) b = (r[0]) ? 8'h07 : 8'($urandom_range(127, 255));
      else b = 8'h0C;
      send(b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle(low);
    check_cursor("final");
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
